// File: rtl/adc_sample_packer.sv
// ---------------------------------------------------------------------------
// adc_sample_packer
//
// Packs pairs of ADC sample beats into four-sample words for the UDP
// streamer. Capture starts either immediately on enable or on the next PPS
// rising edge. Completed words go into a two-entry FIFO. If the FIFO is full
// and nothing pops, the word is dropped and counted, because the ADC side
// cannot be stalled.
//
// Ports
//   adc_clk              single clock for all logic
//   adc_rst              synchronous active-high reset
//   s_axis_tvalid/tdata  ADC beat (sample n in [15:0], n+1 in [31:16]), no tready
//   m_axis_tvalid/tdata  packed word (earliest sample in [15:0])
//   m_axis_tready        downstream accept
//   pps                  asynchronous pulse-per-second input
//   ctrl_enable          capture enable; low forces IDLE immediately
//   ctrl_pps_start       wait in ARMED for a PPS edge before capturing
//   ctrl_test_mode       replace ADC data with a 16-bit ramp
//   stat_running         high while in RUN
//   stat_overflow        sticky dropped-word flag, cleared only by reset
//   stat_word_count      words accepted downstream (wraps)
//   stat_overflow_count  dropped words (saturates)
// ---------------------------------------------------------------------------
module adc_sample_packer #(
    parameter int SAMPLE_WIDTH         = 16,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_TDATA_WIDTH = 64
) (
    input  logic                            adc_clk,
    input  logic                            adc_rst,
    input  logic                            s_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    input  logic                            m_axis_tready,
    input  logic                            pps,
    input  logic                            ctrl_enable,
    input  logic                            ctrl_pps_start,
    input  logic                            ctrl_test_mode,
    output logic                            stat_running,
    output logic                            stat_overflow,
    output logic [31:0]                     stat_word_count,
    output logic [31:0]                     stat_overflow_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // PPS synchronizer and edge detector
    logic r_pps_meta;
    logic r_pps_sync;
    logic r_pps_prev;
    logic w_pps_edge;

    // Capture / packing
    logic                            w_capture;
    logic [SAMPLE_WIDTH-1:0]         r_ramp;
    logic [SAMPLE_WIDTH-1:0]         w_ramp_base;
    logic [SAMPLE_WIDTH-1:0]         w_ramp_plus1;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] w_beat;
    logic                            r_phase;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] r_low;
    logic                            w_word_done;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] w_word;

    // Output FIFO
    logic [C_M_AXIS_TDATA_WIDTH-1:0] r_mem [0:1];
    logic                            r_wr_ptr;
    logic                            r_rd_ptr;
    logic [1:0]                      r_count;
    logic                            w_pop;
    logic                            w_push;
    logic                            w_drop;

    // -----------------------------------------------------------------------
    // PPS: two flops for metastability, a third to find the rising edge.
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_pps_meta <= 1'b0;
            r_pps_sync <= 1'b0;
            r_pps_prev <= 1'b0;
        end else begin
            r_pps_meta <= pps;
            r_pps_sync <= r_pps_meta;
            r_pps_prev <= r_pps_sync;
        end
    end

    assign w_pps_edge = r_pps_sync & ~r_pps_prev;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment ahead of the case is what prevents a latch
    // on any path that does not assign the next state explicitly.
    always_comb begin
        w_state_next = r_state;
        if (!ctrl_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  w_state_next = ctrl_pps_start ? ST_ARMED : ST_RUN;
                ST_ARMED: w_state_next = w_pps_edge ? ST_RUN : ST_ARMED;
                ST_RUN:   w_state_next = ST_RUN;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    assign stat_running = (r_state == ST_RUN);

    // The beat that coincides with the PPS edge is the first sample of the run.
    assign w_capture = ctrl_enable & s_axis_tvalid &
                       ((r_state == ST_RUN) | ((r_state == ST_ARMED) & w_pps_edge));

    // -----------------------------------------------------------------------
    // Test ramp. Outside RUN the ramp is held at zero. That covers the
    // coincident PPS beat, which is captured while still in ARMED.
    // -----------------------------------------------------------------------
    assign w_ramp_base  = (r_state == ST_RUN) ? r_ramp : '0;
    assign w_ramp_plus1 = w_ramp_base + SAMPLE_WIDTH'(1);
    assign w_beat       = ctrl_test_mode ? {w_ramp_plus1, w_ramp_base} : s_axis_tdata;

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_ramp <= '0;
        end else if (w_capture && ctrl_test_mode) begin
            r_ramp <= w_ramp_base + SAMPLE_WIDTH'(2);
        end else if (r_state != ST_RUN) begin
            r_ramp <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Beat packing: the first beat is held, the second completes the word.
    // Leaving for IDLE discards any half word.
    // -----------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_phase <= 1'b0;
            r_low   <= '0;
        end else if (w_state_next == ST_IDLE) begin
            r_phase <= 1'b0;
        end else if (w_capture) begin
            if (!r_phase) begin
                r_low <= w_beat;
            end
            r_phase <= ~r_phase;
        end
    end

    assign w_word_done = w_capture & r_phase;
    assign w_word      = {w_beat, r_low};

    // -----------------------------------------------------------------------
    // Two-entry FIFO. The completed word is written straight into storage,
    // so it appears on m_axis one cycle after its second beat. A full FIFO
    // that is popping in the same cycle still accepts the push.
    // -----------------------------------------------------------------------
    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign w_pop         = m_axis_tvalid & m_axis_tready;
    assign w_push        = w_word_done & ((r_count != 2'd2) | w_pop);
    assign w_drop        = w_word_done & (r_count == 2'd2) & ~w_pop;

    // NOTE: the storage is reset because m_axis_tdata must read zero out of
    // reset; a larger RAM-based buffer would normally be left unreset.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Status counters
    // -----------------------------------------------------------------------
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            stat_word_count     <= '0;
            stat_overflow_count <= '0;
            stat_overflow       <= 1'b0;
        end else begin
            if (w_pop) begin
                stat_word_count <= stat_word_count + 32'd1;
            end
            if (w_drop) begin
                stat_overflow <= 1'b1;
                if (stat_overflow_count != 32'hFFFF_FFFF) begin
                    stat_overflow_count <= stat_overflow_count + 32'd1;
                end
            end
        end
    end

endmodule
